spi_stream_receiver: RTL

//  SPI slave (mode 0, MSB first) that deserialises host-driven mosi/sck frames into WORD_WIDTH-bit words.

---
 rtl/spi_stream_receiver_pkg.sv | 22 ++
 rtl/spi_stream_receiver_fifo.sv | 58 +++++
 rtl/spi_stream_receiver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/spi_stream_receiver_pkg.sv
// Shared constants and types for the SPI-to-AXI-Stream receiver.
// Covers SPI mode, synchroniser depth, default word size and receiver FSM states.
package spi_stream_receiver_pkg;

    localparam bit SPI_CPOL = 1'b0;
    localparam bit SPI_CPHA = 1'b0;
    localparam int SYNC_STAGES = 2;
    localparam int DEFAULT_WORD_WIDTH = 16;
    localparam int AXIS_BUNDLE_W = DEFAULT_WORD_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_FLUSH
    } rx_state_e;

    // Width of one FIFO entry: the data word plus its tlast flag.
    function automatic int bundle_width(input int word_width);
        return word_width + 1;
    endfunction

endpackage

// File: rtl/spi_stream_receiver_fifo.sv
// Synchronous first-word-fall-through FIFO with fill count and full/empty flags.
// Uses extended pointers, so full is "MSBs differ, rest equal" and empty is "pointers equal".
module stream_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    // A push into a full FIFO is still legal when the head is popped in the same cycle.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    assign wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    // Head is shown combinationally; forced to zero while empty so outputs read 0 after reset.
    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/spi_stream_receiver.sv
// SPI mode-0 slave that deserialises MSB-first words onto an AXI-Stream master port.
// One word is held in staging so tlast can be attached when chip select rises.
module spi_stream_receiver
    import spi_stream_receiver_pkg::*;
#(
    parameter int WORD_WIDTH         = DEFAULT_WORD_WIDTH,
    parameter int FIFO_DEPTH         = 32,
    parameter int ALMOST_FULL_MARGIN = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  mosi,
    input  logic                  csn,
    output logic                  miso,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [WORD_WIDTH-1:0] m_axis_tdata,
    input  logic                  clearErrors,
    output logic                  overflow,
    output logic                  frameError
);

    localparam int BUNDLE_W = bundle_width(WORD_WIDTH);
    localparam int BC_W     = $clog2(WORD_WIDTH + 1);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_WIDTH - 1);
    localparam logic [CNT_W-1:0] BUSY_LVL = CNT_W'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

    // Index SYNC_STAGES-1 is the synchronised level; index SYNC_STAGES is the edge-detect stage.
    logic [SYNC_STAGES:0] sck_pipe_q, mosi_pipe_q, csn_pipe_q;
    logic sck_rise_q, csn_rise_q, csn_fall_q;
    logic mosi_bit;

    rx_state_e              state_q, state_d;
    logic [BC_W-1:0]        bit_count_q, bit_count_d;
    logic [WORD_WIDTH-1:0]  shift_q, shift_d;
    logic [WORD_WIDTH-1:0]  staged_q, staged_d;
    logic                   staged_valid_q, staged_valid_d;
    logic [WORD_WIDTH-1:0]  next_word;
    logic                   push;
    logic [BUNDLE_W-1:0]    push_data;
    logic                   frame_err_set;

    logic                   pop;
    logic [BUNDLE_W-1:0]    fifo_data;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;
    logic                   miso_q, overflow_q, frame_error_q;

    // Edge pulses are registered, so mosi takes one more stage to stay aligned with sck_rise_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_pipe_q  <= '0;
            mosi_pipe_q <= '0;
            csn_pipe_q  <= '0;
            sck_rise_q  <= 1'b0;
            csn_rise_q  <= 1'b0;
            csn_fall_q  <= 1'b0;
        end else begin
            sck_pipe_q  <= {sck_pipe_q[SYNC_STAGES-1:0], sck};
            mosi_pipe_q <= {mosi_pipe_q[SYNC_STAGES-1:0], mosi};
            csn_pipe_q  <= {csn_pipe_q[SYNC_STAGES-1:0], csn};
            sck_rise_q  <= sck_pipe_q[SYNC_STAGES-1] & ~sck_pipe_q[SYNC_STAGES];
            csn_rise_q  <= csn_pipe_q[SYNC_STAGES-1] & ~csn_pipe_q[SYNC_STAGES];
            csn_fall_q  <= ~csn_pipe_q[SYNC_STAGES-1] & csn_pipe_q[SYNC_STAGES];
        end
    end

    assign mosi_bit  = mosi_pipe_q[SYNC_STAGES];
    assign next_word = {shift_q[WORD_WIDTH-2:0], mosi_bit};

    always_comb begin
        state_d        = state_q;
        bit_count_d    = bit_count_q;
        shift_d        = shift_q;
        staged_d       = staged_q;
        staged_valid_d = staged_valid_q;
        push           = 1'b0;
        push_data      = '0;
        frame_err_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (csn_fall_q) begin
                    state_d     = ST_RECEIVE;
                    bit_count_d = '0;
                end
            end
            ST_RECEIVE: begin
                if (sck_rise_q) begin
                    shift_d = next_word;
                    if (bit_count_q == LAST_BIT) begin
                        bit_count_d    = '0;
                        staged_d       = next_word;
                        staged_valid_d = 1'b1;
                        push           = staged_valid_q;
                        push_data      = {1'b0, staged_q};
                    end else begin
                        bit_count_d = bit_count_q + BC_W'(1);
                    end
                end
                // A rise landing with the final bit completes the word, so no frame error then.
                if (csn_rise_q) begin
                    state_d       = ST_FLUSH;
                    frame_err_set = (bit_count_d != '0);
                    bit_count_d   = '0;
                end
            end
            ST_FLUSH: begin
                push           = staged_valid_q;
                push_data      = {1'b1, staged_q};
                staged_valid_d = 1'b0;
                bit_count_d    = '0;
                state_d        = csn_fall_q ? ST_RECEIVE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            bit_count_q    <= '0;
            shift_q        <= '0;
            staged_q       <= '0;
            staged_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_count_q    <= bit_count_d;
            shift_q        <= shift_d;
            staged_q       <= staged_d;
            staged_valid_q <= staged_valid_d;
        end
    end

    assign pop  = m_axis_tvalid && m_axis_tready;
    assign drop = push && fifo_full && !pop;

    stream_fifo #(
        .WIDTH (BUNDLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // miso only moves between words so the host never sees it change mid-word.
    always_ff @(posedge clk) begin
        if (reset) begin
            miso_q        <= 1'b0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            if (csn_pipe_q[SYNC_STAGES] || bit_count_q == '0) begin
                miso_q <= (fifo_count >= BUSY_LVL);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clearErrors) begin
                overflow_q <= 1'b0;
            end
            if (frame_err_set) begin
                frame_error_q <= 1'b1;
            end else if (clearErrors) begin
                frame_error_q <= 1'b0;
            end
        end
    end

    assign miso          = miso_q;
    assign overflow      = overflow_q;
    assign frameError    = frame_error_q;
    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tlast  = fifo_data[BUNDLE_W-1];
    assign m_axis_tdata  = fifo_data[WORD_WIDTH-1:0];

endmodule
